vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
// - Raster timing source for the VGA path: free-running horizontal/vertical counters produce DrawX/DrawY,
//   the display-enable flag blank, and active-low hs/vs for the DAC/connector.
// - Sits directly upstream of every *_mapper stage. Mappers consume DrawX, DrawY, vga_clk and blank;
//   their colour output lags DrawX by 2 clocks (ROM read + output register).
// - hs/vs are delayed by SYNC_DELAY clocks so they line up with mapper colour at the pins.
// PARAMETERS
// - H_VISIBLE   640  active pixels per line
// - H_FRONT     16   horizontal front porch, in clocks
// - H_SYNC      96   horizontal sync width, in clocks
// - H_BACK      48   horizontal back porch, in clocks
// - V_VISIBLE   480  active lines per frame
// - V_FRONT     10   vertical front porch, in lines
// - V_SYNC      2    vertical sync width, in lines
// - V_BACK      33   vertical back porch, in lines
// - SYNC_DELAY  2    pipeline depth applied to hs/vs, 0..7. 0 means no delay (hs/vs aligned with DrawX).
// PORTS
// - vga_clk      in   1   pixel clock, 25 MHz; sole clock
// - reset_n      in   1   asynchronous, active-low reset
// - DrawX        out  10  current horizontal count, 0..H_TOTAL-1
// - DrawY        out  10  current vertical count, 0..V_TOTAL-1
// - blank        out  1   1 = visible pixel (DrawX<H_VISIBLE && DrawY<V_VISIBLE); aligned with DrawX
// - hs           out  1   horizontal sync, active low; delayed SYNC_DELAY clocks
// - vs           out  1   vertical sync, active low; delayed SYNC_DELAY clocks
// - line_start   out  1   1-clock pulse while DrawX==0 following a horizontal wrap
// - frame_start  out  1   1-clock pulse while DrawX==0 && DrawY==0 following a frame wrap
// - frame_count  out  16  frame counter for animation; increments on every frame wrap
// BEHAVIOUR
// - Totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
// - Reset (async assert, synchronous release): DrawX=0, DrawY=0, blank=0, hs=1, vs=1, line_start=0,
//   frame_start=0, frame_count=0. The entire sync delay pipeline is loaded with 1.
// - blank=0 during reset even though the counters read (0,0).
// - Every vga_clk edge, DrawX increments. At H_TOTAL-1 it wraps to 0 and DrawY increments.
// - DrawY wraps from V_TOTAL-1 to 0 on the same edge that DrawX wraps.
//   - That edge also increments frame_count, which wraps 0xFFFF->0.
// - The counters are the output registers. All flags are registered and computed from next-state counter
//   values, so they are valid in the same cycle as the DrawX/DrawY they describe (0-latency alignment).
// - Raw sync decode:
//   - hs_raw = 0 while H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
//   - vs_raw = 0 while V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491, for the whole line.
// - hs/vs = hs_raw/vs_raw passed through the SYNC_DELAY-stage shift register.
// - line_start and frame_start are never asserted in the first cycle after reset release.
//   - Their first assertion is at the first wrap.
//   - frame_start implies line_start.
// - Reset asserted mid-frame: all outputs return to their reset values immediately.
//   - The next frame starts cleanly from (0,0) after release.
//   - The first frame_start after release occurs 420000 clocks later.
// - No handshake: outputs advance unconditionally. Downstream stages must sample every clock.
// STRUCTURE
// - Shared package vga_timing_pkg holds:
//   - the 640x480@60 constants and the derived H_TOTAL/V_TOTAL/sync-start/sync-end localparams;
//   - typedef coord_t = logic [9:0], used by all *_mapper stages.
// - Sub-module vga_delay_line: parameterised DEPTH x WIDTH shift register with async active-low reset to
//   a RESET_VAL parameter. DEPTH=0 is a wire-through. It is instantiated once for {hs_raw, vs_raw}, WIDTH=2.
// - Counter logic, flag decode and frame_count live in vga_timing_gen.
// TESTING
// - Reset: hold reset_n=0 for 5 clocks -> DrawX=0, DrawY=0, blank=0, hs=1, vs=1, frame_count=0.
//   - First clock after release -> DrawX=1, blank=1.
// - Line timing, SYNC_DELAY=2:
//   - blank high for exactly 640 clocks per visible line.
//   - hs falls on the 2nd clock after DrawX==656 and stays low for 96 clocks.
//   - line_start period is 800 clocks.
// - Frame timing:
//   - frame_start period is 420000 clocks; 307200 blank-high clocks per frame.
//   - vs low for exactly 1600 clocks, starting 2 clocks after (DrawX,DrawY)=(0,490).
//   - frame_count increments by 1 per frame_start.
// - Wrap boundary: at (799,524) the next clock gives DrawX=0, DrawY=0, frame_start=1, line_start=1, blank=1.
//   - frame_count 0xFFFF -> 0x0000 (preload via force).
// - Mid-frame reset: assert reset_n=0 at (300,200) -> outputs at reset values within the same cycle.
//   - After release, DrawY restarts at 0 and hs/vs remain 1 for the SYNC_DELAY clocks after release.
// - SYNC_DELAY=0 build: hs low exactly while DrawX is 656..751.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants, derived totals/sync windows and the shared coordinate type
package vga_timing_pkg;
  typedef logic [9:0] coord_t;
  localparam int H_VISIBLE    = 640;
  localparam int H_FRONT      = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BACK       = 48;
  localparam int V_VISIBLE    = 480;
  localparam int V_FRONT      = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BACK       = 33;
  localparam int SYNC_DELAY   = 2;
  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH x WIDTH shift register, async active-low reset to RESET_VAL; DEPTH=0 is a wire
//   i_clk, i_rst_n : clock, async active-low reset
//   i_d / o_q      : data in / data delayed by DEPTH clocks
module vga_delay_line #(
  parameter int               DEPTH     = 2,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  if (DEPTH == 0) begin : g_wire
    assign o_q = i_d;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_pipe [DEPTH];
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RESET_VAL;
      end else begin
        r_pipe[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
    assign o_q = r_pipe[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster counters, visible/sync decode and frame counter for the VGA path
//   vga_clk, reset_n     : pixel clock, async active-low reset
//   DrawX, DrawY         : current raster position (the counter registers themselves)
//   blank                : 1 on a visible pixel, aligned with DrawX/DrawY
//   hs, vs               : active-low syncs, delayed SYNC_DELAY clocks to match mapper colour latency
//   line_start           : pulse at DrawX==0 after a line wrap
//   frame_start          : pulse at (0,0) after a frame wrap
//   frame_count          : frames completed since reset, wraps at 16 bits
module vga_timing_gen #(
  parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT    = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int H_BACK     = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT    = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int V_BACK     = vga_timing_pkg::V_BACK,
  parameter int SYNC_DELAY = vga_timing_pkg::SYNC_DELAY
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);
  import vga_timing_pkg::*;
  localparam coord_t H_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t H_VIS   = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS   = coord_t'(V_VISIBLE);
  localparam coord_t HS_BEG  = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_BEG  = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
  coord_t      r_x, r_y;
  logic        r_blank, r_line_start, r_frame_start, r_hs_raw, r_vs_raw;
  logic [15:0] r_frame_count;
  logic        w_hwrap, w_vwrap;
  coord_t      w_x_nxt, w_y_nxt;
  assign w_hwrap = r_x == H_LAST;
  assign w_vwrap = w_hwrap && r_y == V_LAST;
  assign w_x_nxt = w_hwrap ? '0 : r_x + coord_t'(1);
  assign w_y_nxt = w_vwrap ? '0 : w_hwrap ? r_y + coord_t'(1) : r_y;
  // Flags are decoded from the next-state counters so they land in the same cycle as the coordinates.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_blank       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_hs_raw      <= 1'b1;
      r_vs_raw      <= 1'b1;
      r_frame_count <= '0;
    end else begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_blank       <= w_x_nxt < H_VIS && w_y_nxt < V_VIS;
      r_line_start  <= w_hwrap;
      r_frame_start <= w_vwrap;
      r_hs_raw      <= !(w_x_nxt >= HS_BEG && w_x_nxt < HS_END);
      r_vs_raw      <= !(w_y_nxt >= VS_BEG && w_y_nxt < VS_END);
      r_frame_count <= w_vwrap ? r_frame_count + 16'd1 : r_frame_count;
    end
  end
  vga_delay_line #(
    .DEPTH     (SYNC_DELAY),
    .WIDTH     (2),
    .RESET_VAL (2'b11)
  ) u_sync_dly (
    .i_clk   (vga_clk),
    .i_rst_n (reset_n),
    .i_d     ({r_hs_raw, r_vs_raw}),
    .o_q     ({hs, vs})
  );
  assign DrawX       = r_x;
  assign DrawY       = r_y;
  assign blank       = r_blank;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of line timing (default and zero-delay builds) and frame/wrap/reset behaviour on a shrunken raster
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  d_x, d_y, z_x, z_y, s_x, s_y;
  logic        d_bl, d_hs, d_vs, d_ls, d_fs;
  logic        z_bl, z_hs, z_vs, z_ls, z_fs;
  logic        s_bl, s_hs, s_vs, s_ls, s_fs;
  logic [15:0] d_fc, z_fc, s_fc;

  vga_timing_gen u_def (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(d_x), .DrawY(d_y), .blank(d_bl), .hs(d_hs), .vs(d_vs),
    .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc));

  vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(z_x), .DrawY(z_y), .blank(z_bl), .hs(z_hs), .vs(z_vs),
    .line_start(z_ls), .frame_start(z_fs), .frame_count(z_fc));

  // 15 x 10 raster: hsync at x 10..12, vsync on lines 7..8, 150 clocks per frame, 48 visible pixels
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(2)
  ) u_sm (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(s_x), .DrawY(s_y), .blank(s_bl), .hs(s_hs), .vs(s_vs),
    .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc));

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int  d_bl_l1, d_hs_fall_n, d_hs_fall_x, d_hs_rise_n, d_hs_low, d_ls_first, d_ls_prev, d_ls_per_bad, d_ls_cnt, d_ls_x_bad;
  int  z_hs_bad, z_hs_low;
  int  s_fs_first, s_fs_prev, s_fs_per_bad, s_fs_cnt, s_fs_no_ls, s_bl_f0;
  int  s_vs_fall_n, s_vs_fall_x, s_vs_fall_y, s_vs_rise_n;
  logic d_hs_p, s_vs_p, ok;

  initial begin
    d_bl_l1 = 0; d_hs_fall_n = -1; d_hs_fall_x = -1; d_hs_rise_n = -1; d_hs_low = 0;
    d_ls_first = -1; d_ls_prev = -1; d_ls_per_bad = 0; d_ls_cnt = 0; d_ls_x_bad = 0;
    z_hs_bad = 0; z_hs_low = 0;
    s_fs_first = -1; s_fs_prev = -1; s_fs_per_bad = 0; s_fs_cnt = 0; s_fs_no_ls = 0; s_bl_f0 = 0;
    s_vs_fall_n = -1; s_vs_fall_x = -1; s_vs_fall_y = -1; s_vs_rise_n = -1;
    d_hs_p = 1'b1; s_vs_p = 1'b1;

    repeat (5) tick;
    chk("rst_x", d_x, 0);
    chk("rst_y", d_y, 0);
    chk("rst_blank", d_bl, 0);
    chk("rst_hs", d_hs, 1);
    chk("rst_vs", d_vs, 1);
    chk("rst_fc", d_fc, 0);
    chk("rst_ls", d_ls, 0);
    chk("rst_fs", d_fs, 0);

    reset_n = 1'b1;
    for (int n = 1; n <= 2400; n++) begin
      tick;
      if (n == 1) begin
        chk("first_x", d_x, 1);
        chk("first_blank", d_bl, 1);
        chk("first_ls", d_ls, 0);
        chk("first_fs", s_fs, 0);
      end
      if (d_y == 1 && d_bl) d_bl_l1++;
      if (!d_hs) d_hs_low++;
      if (!d_hs && d_hs_p && d_hs_fall_n < 0) begin d_hs_fall_n = n; d_hs_fall_x = d_x; end
      if (d_hs && !d_hs_p && d_hs_rise_n < 0) d_hs_rise_n = n;
      d_hs_p = d_hs;
      if (d_ls) begin
        if (d_ls_first < 0) d_ls_first = n;
        else if (n - d_ls_prev != 800) d_ls_per_bad++;
        if (d_x != 0) d_ls_x_bad++;
        d_ls_prev = n;
        d_ls_cnt++;
      end
      if (z_hs != !(z_x >= 656 && z_x <= 751)) z_hs_bad++;
      if (!z_hs) z_hs_low++;
      if (n <= 150 && s_bl) s_bl_f0++;
      if (s_fs) begin
        if (s_fs_first < 0) s_fs_first = n;
        else if (n - s_fs_prev != 150) s_fs_per_bad++;
        if (!s_ls) s_fs_no_ls++;
        s_fs_prev = n;
        s_fs_cnt++;
      end
      if (!s_vs && s_vs_p && s_vs_fall_n < 0) begin s_vs_fall_n = n; s_vs_fall_x = s_x; s_vs_fall_y = s_y; end
      if (s_vs && !s_vs_p && s_vs_rise_n < 0) s_vs_rise_n = n;
      s_vs_p = s_vs;
      if (n == 150) begin
        chk("sm_wrap_x", s_x, 0);
        chk("sm_wrap_y", s_y, 0);
        chk("sm_wrap_blank", s_bl, 1);
        chk("sm_wrap_ls", s_ls, 1);
        chk("sm_wrap_fs", s_fs, 1);
        chk("sm_wrap_fc", s_fc, 1);
      end
    end
    chk("line1_blank_cnt", d_bl_l1, 640);
    chk("hs_fall_x", d_hs_fall_x, 658);
    chk("hs_low_len", d_hs_rise_n - d_hs_fall_n, 96);
    chk("hs_low_total", d_hs_low, 288);
    chk("ls_first", d_ls_first, 800);
    chk("ls_period_bad", d_ls_per_bad, 0);
    chk("ls_count", d_ls_cnt, 3);
    chk("ls_x_bad", d_ls_x_bad, 0);
    chk("vs_idle", d_vs, 1);
    chk("d0_hs_window_bad", z_hs_bad, 0);
    chk("d0_hs_low_total", z_hs_low, 288);
    chk("sm_fs_first", s_fs_first, 150);
    chk("sm_fs_period_bad", s_fs_per_bad, 0);
    chk("sm_fs_count", s_fs_cnt, 16);
    chk("sm_fs_no_ls", s_fs_no_ls, 0);
    chk("sm_fc", s_fc, 16);
    chk("sm_blank_per_frame", s_bl_f0, 48);
    chk("sm_vs_fall_x", s_vs_fall_x, 2);
    chk("sm_vs_fall_y", s_vs_fall_y, 7);
    chk("sm_vs_low_len", s_vs_rise_n - s_vs_fall_n, 30);

    force u_sm.r_frame_count = 16'hFFFF;
    tick;
    release u_sm.r_frame_count;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      tick;
      ok = s_x == 14 && s_y == 9;
    end
    chk("wait_last_pixel", ok, 1);
    chk("fc_preload", s_fc, 16'hFFFF);
    tick;
    chk("wrap_x", s_x, 0);
    chk("wrap_y", s_y, 0);
    chk("wrap_fs", s_fs, 1);
    chk("wrap_ls", s_ls, 1);
    chk("wrap_blank", s_bl, 1);
    chk("fc_rollover", s_fc, 0);

    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      tick;
      ok = s_x == 5 && s_y == 7;
    end
    chk("wait_mid_frame", ok, 1);
    chk("pre_rst_vs", s_vs, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_x", s_x, 0);
    chk("mid_rst_y", s_y, 0);
    chk("mid_rst_blank", s_bl, 0);
    chk("mid_rst_vs", s_vs, 1);
    chk("mid_rst_hs", s_hs, 1);
    chk("mid_rst_fc", s_fc, 0);
    chk("mid_rst_def_x", d_x, 0);
    repeat (2) tick;
    reset_n = 1'b1;
    tick;
    chk("rel1_x", s_x, 1);
    chk("rel1_y", s_y, 0);
    chk("rel1_hs", s_hs, 1);
    chk("rel1_vs", s_vs, 1);
    chk("rel1_ls", s_ls, 0);
    tick;
    chk("rel2_y", s_y, 0);
    chk("rel2_hs", s_hs, 1);
    chk("rel2_vs", s_vs, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
